top_level: RTL and testbench

Board-level accumulator for a 4-digit 7-segment, 8-LED, 8-switch, 4-button FPGA board. Button presses step an 8-bit entry value. A commit press adds the entry to, or subtracts it from, a 16-bit accumulator. The accumulator (or the entry) is shown in hex on a multiplexed 4-digit display. It is the design's top module and contains input conditioning, datapath and display scan.

---
 rtl/top_pkg.sv | 51 +++++
 rtl/top_button_conditioner.sv | 76 +++++++
 rtl/top_level.sv | 104 ++++++++++
 tb/tb_top_level.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared constants for the board accumulator: default parameters, button
// indices and active-low 7-segment glyphs ({g,f,e,d,c,b,a}).
package top_pkg;

    localparam int unsigned DEFAULT_SCAN_DIV        = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

    localparam int unsigned BTN_INC    = 3;
    localparam int unsigned BTN_COMMIT = 2;
    localparam int unsigned BTN_CLRA   = 1;
    localparam int unsigned BTN_CLRE   = 0;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/top_button_conditioner.sv
// One push-button: 2-flop synchroniser, optional debounce (TOP_DEBOUNCE_EN),
// rising-edge detect into a single-cycle registered pulse.
module button_conditioner
    import top_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic       sync_p0;
    logic       sync_p1;
    logic       level;
    logic       level_d;
    logic       armed;
    logic [1:0] fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

`ifdef TOP_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_p1 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync_p1;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = stable;
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign level = sync_p1;
`endif

    // Arm only after the synchroniser holds real samples and has seen the
    // button released, so a press held through reset never pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
            armed   <= 1'b0;
            fill    <= 2'd0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            if (fill != 2'd2)
                fill <= fill + 2'd1;
            if (fill == 2'd2 && !sync_p1)
                armed <= 1'b1;
            pulse <= level & ~level_d & armed;
        end
    end

endmodule

// File: rtl/top_level.sv
// Board accumulator top: button conditioning, 8-bit entry / 16-bit accumulator
// datapath and 4-digit hex display scan. Optional macro: TOP_DEBOUNCE_EN.
module top_level
    import top_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = DEFAULT_SCAN_DIV,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic [7:0] switch,
    input  logic [3:0] button,
    output logic [6:0] digits,
    output logic [3:0] sel,
    output logic [7:0] led
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic             rst;
    logic [3:0]       pulse;
    logic             op_p0, op_p1;
    logic             dsel_p0, dsel_p1;
    logic [7:0]       entry;
    logic [15:0]      acc;
    logic [15:0]      disp;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic [3:0]       nib;
    logic             unused_switch;

    assign rst           = switch[1];
    assign unused_switch = ^{switch[7:4], switch[2]};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk  (clk),
            .rst  (rst),
            .btn  (button[i]),
            .pulse(pulse[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_p0   <= 1'b0;
            op_p1   <= 1'b0;
            dsel_p0 <= 1'b0;
            dsel_p1 <= 1'b0;
        end else begin
            op_p0   <= switch[3];
            op_p1   <= op_p0;
            dsel_p0 <= switch[0];
            dsel_p1 <= dsel_p0;
        end
    end

    // Commit consumes the old entry in the same cycle it zeroes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry <= 8'h00;
            acc   <= 16'h0000;
            led   <= 8'h00;
        end else begin
            if (pulse[BTN_CLRE] || pulse[BTN_COMMIT])
                entry <= 8'h00;
            else if (pulse[BTN_INC])
                entry <= entry + 8'd1;

            if (pulse[BTN_CLRA])
                acc <= 16'h0000;
            else if (pulse[BTN_COMMIT])
                acc <= op_p1 ? acc - {8'h00, entry} : acc + {8'h00, entry};

            led <= entry;
        end
    end

    always_comb begin
        disp    = dsel_p1 ? {8'h00, entry} : acc;
        idx_nxt = idx + 2'd1;
        nib     = disp[{idx_nxt, 2'b00} +: 4];
    end

    // Glyph and enable are latched together at the start of each digit slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
            sel     <= 4'b1110;
            digits  <= SEG_0;
        end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= idx_nxt;
            sel     <= ~(4'b0001 << idx_nxt);
            digits  <= hex2seg(nib);
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Randomised self-checking bench for top_level against a behavioural model of
// the entry/accumulator rules; the display is read back by decoding the scan.
module tb_top_level;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 16;
`ifdef TOP_DEBOUNCE_EN
    localparam int PULSE_MIN_HOLD  = DEBOUNCE_CYCLES + 1;
`else
    localparam int PULSE_MIN_HOLD  = 1;
`endif

    localparam logic [3:0] B_INC  = 4'b1000;
    localparam logic [3:0] B_COM  = 4'b0100;
    localparam logic [3:0] B_CLRA = 4'b0010;
    localparam logic [3:0] B_CLRE = 4'b0001;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic [7:0] sw;
    logic [3:0] btn;
    logic [6:0] digits;
    logic [3:0] sel;
    logic [7:0] led;

    logic [7:0]  m_e;
    logic [15:0] m_a;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    top_level #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk   (clk),
        .switch(sw),
        .button(btn),
        .digits(digits),
        .sel   (sel),
        .led   (led)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Model: applies one set of simultaneous presses using the spec's priorities.
    task automatic model_apply(input logic [3:0] mask);
        logic [7:0]  e_old;
        e_old = m_e;
        if (mask & B_CLRA)
            m_a = 16'h0000;
        else if (mask & B_COM)
            m_a = sw[3] ? m_a - 16'(e_old) : m_a + 16'(e_old);
        if ((mask & B_CLRE) || (mask & B_COM))
            m_e = 8'h00;
        else if (mask & B_INC)
            m_e = e_old + 8'd1;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk);
        btn = mask;
        repeat (hold) @(negedge clk);
        btn = 4'b0000;
        repeat (60) @(negedge clk);
        if (hold >= PULSE_MIN_HOLD)
            model_apply(mask);
    endtask

    task automatic read_display(output logic [15:0] val, output logic ok);
        logic [3:0] seen;
        int         pos;
        int         nibv;
        seen = 4'b0000;
        val  = 16'h0000;
        ok   = 1'b1;
        repeat (8 * SCAN_DIV + 2) begin
            @(negedge clk);
            case (sel)
                4'b1110: pos = 0;
                4'b1101: pos = 1;
                4'b1011: pos = 2;
                4'b0111: pos = 3;
                default: pos = -1;
            endcase
            nibv = -1;
            for (int g = 0; g < 16; g++)
                if (GLYPH[g] === digits) nibv = g;
            if (pos < 0 || nibv < 0) begin
                ok = 1'b0;
            end else begin
                val[pos*4 +: 4] = 4'(nibv);
                seen[pos]       = 1'b1;
            end
        end
        if (seen != 4'b1111) ok = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [15:0] v;
        logic        ok;
        read_display(v, ok);
        check_val({tag, ".led"}, 32'(led), 32'(m_e));
        check_val({tag, ".scan"}, 32'(ok), 32'd1);
        check_val({tag, ".disp"}, 32'(v), 32'(sw[0] ? {8'h00, m_e} : m_a));
    endtask

    task automatic check_disp(input string tag, input logic [15:0] exp);
        logic [15:0] v;
        logic        ok;
        read_display(v, ok);
        check_val({tag, ".scan"}, 32'(ok), 32'd1);
        check_val({tag, ".disp"}, 32'(v), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sw  = 8'h02;
        btn = 4'b0000;
        m_e = 8'h00;
        m_a = 16'h0000;
        repeat (3) @(negedge clk);
        check_val("reset.led", 32'(led), 32'h00);
        check_val("reset.sel", 32'(sel), 32'b1110);
        check_val("reset.digits", 32'(digits), 32'b1000000);
        sw[1] = 1'b0;
        repeat (5) @(negedge clk);
        check_disp("reset", 16'h0000);

        // Add
        repeat (3) press(B_INC, 50);
        check_val("add.led", 32'(led), 32'h03);
        press(B_COM, 50);
        check_val("add.led_cleared", 32'(led), 32'h00);
        check_disp("add", 16'h0003);

        // Subtract, then underflow wrap
        @(negedge clk);
        sw[3] = 1'b1;
        repeat (2) press(B_INC, 50);
        press(B_COM, 50);
        check_disp("sub", 16'h0001);
        repeat (2) press(B_INC, 50);
        press(B_COM, 50);
        check_disp("sub_wrap", 16'hFFFF);
        check_state("sub_model");

        // Entry wrap and long hold
        repeat (256) press(B_INC, 50);
        check_val("wrap.led", 32'(led), 32'h00);
        press(B_INC, 1000);
        check_val("hold.led", 32'(led), 32'h01);

        // Short press: rejected only when debouncing
        press(B_INC, 10);
`ifdef TOP_DEBOUNCE_EN
        check_val("short.led", 32'(led), 32'h01);
`else
        check_val("short.led", 32'(led), 32'h02);
`endif
        check_state("short_model");

        // Display select
        press(B_CLRE, 50);
        repeat (42) press(B_INC, 50);
        @(negedge clk);
        sw[0] = 1'b1;
        repeat (10) @(negedge clk);
        check_disp("dsel", 16'h002A);
        press(B_CLRE, 50);
        check_val("clre.led", 32'(led), 32'h00);
        check_disp("clre", 16'h0000);
        @(negedge clk);
        sw[0] = 1'b0;
        repeat (10) @(negedge clk);
        check_disp("before_clra", 16'hFFFF);
        press(B_CLRA, 50);
        check_disp("clra", 16'h0000);

        // Reset asserted while a button is held
        press(B_INC, 50);
        press(B_COM, 50);
        @(negedge clk);
        btn = B_INC;
        repeat (2) @(negedge clk);
        sw[1] = 1'b1;
        repeat (3) @(negedge clk);
        sw[1] = 1'b0;
        repeat (45) @(negedge clk);
        btn = 4'b0000;
        repeat (60) @(negedge clk);
        sw  = 8'h00;
        m_e = 8'h00;
        m_a = 16'h0000;
        repeat (5) @(negedge clk);
        check_state("rst_held");
        press(B_INC, 50);
        check_val("rst_repress.led", 32'(led), 32'h01);

        // Randomised operations
        for (int it = 0; it < 30; it++) begin
            int          r;
            logic [3:0]  m;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: press(4'b0001 << r, 50);
                4: begin
                    m = 4'($urandom_range(1, 15));
                    press(m, 50);
                end
                5, 6: begin
                    @(negedge clk);
                    if (r == 5) sw[3] = ~sw[3];
                    else        sw[0] = ~sw[0];
                    sw[7:4] = 4'($urandom);
                    sw[2]   = 1'($urandom);
                    repeat (10) @(negedge clk);
                end
                7: press(4'b0001 << $urandom_range(0, 3), 10);
                default: press(B_INC, 50 + int'($urandom_range(0, 30)));
            endcase
            check_state("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
